cpu_addr_alu: RTL and testbench



---
 rtl/cpu_addr_alu_pkg.sv | 41 ++++
 rtl/addr_unit.sv | 99 +++++++++
 rtl/cpu_addr_alu.sv | 116 +++++++++++
 tb/tb_cpu_addr_alu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_addr_alu_pkg.sv
// cpu_addr_alu_pkg
// Shared encodings for the 65C02 datapath core: ABL base/offset select
// codes, ABH base select codes and the ALU function enum.
// Used by addr_unit and cpu_addr_alu.
// Optional feature macro used elsewhere in this slice: CPU_BCD_EN.
package cpu_addr_alu_pkg;

  // abl_op[3:2]: ADL adder base
  localparam logic [1:0] ABL_BASE_ABL = 2'b00;
  localparam logic [1:0] ABL_BASE_PCL = 2'b01;
  localparam logic [1:0] ABL_BASE_AHL = 2'b10;
  localparam logic [1:0] ABL_BASE_REG = 2'b11;

  // abl_op[1:0]: ADL adder offset
  localparam logic [1:0] ABL_OFS_ZERO = 2'b00;
  localparam logic [1:0] ABL_OFS_REG  = 2'b01;
  localparam logic [1:0] ABL_OFS_DB   = 2'b10;
  localparam logic [1:0] ABL_OFS_FF   = 2'b11;

  // abh_op[1:0]: ADH adder base
  localparam logic [1:0] ABH_BASE_ABH   = 2'b00;
  localparam logic [1:0] ABH_BASE_PCH   = 2'b01;
  localparam logic [1:0] ABH_BASE_DB    = 2'b10;
  localparam logic [1:0] ABH_BASE_STACK = 2'b11;

  localparam logic [7:0] STACK_PAGE  = 8'h01;
  localparam logic [7:0] VECTOR_PAGE = 8'hFF;

  typedef enum logic [4:0] {
    ALU_OR    = 5'h00,
    ALU_AND   = 5'h01,
    ALU_EOR   = 5'h02,
    ALU_ADD   = 5'h03,
    ALU_SUB   = 5'h04,
    ALU_PASSR = 5'h05,
    ALU_PASSM = 5'h06,
    ALU_SHL   = 5'h07,
    ALU_SHR   = 5'h08
  } alu_op_e;

endpackage

// File: rtl/addr_unit.sv
// addr_unit
// Address generator: ADL/ADH adders, the ABL/ABH address registers,
// the AHL temporary and the program counter.
// Ports:
//   clk, RST          clock, synchronous active-high reset
//   abl_op[3:0]       ADL base [3:2] / offset [1:0] select
//   abl_ci            ADL adder carry in
//   abh_op[2:0]       ADH base [1:0], [2]=use ADL carry as ADH carry in
//   abh_ff            force ADH to 0xFF
//   ld_ahl            AHL <= DB
//   ld_pc, inc_pc     PC load from AD / increment
//   DB, REG [7:0]     data bus, register file read value
//   AD [15:0]         combinational {ADH, ADL}
//   PCL, PCH [7:0]    program counter
//   abl_co            ADL adder carry out
import cpu_addr_alu_pkg::*;

module addr_unit (
  input  logic        clk,
  input  logic        RST,
  input  logic [3:0]  abl_op,
  input  logic        abl_ci,
  input  logic [2:0]  abh_op,
  input  logic        abh_ff,
  input  logic        ld_ahl,
  input  logic        ld_pc,
  input  logic        inc_pc,
  input  logic [7:0]  DB,
  input  logic [7:0]  REG,
  output logic [15:0] AD,
  output logic [7:0]  PCL,
  output logic [7:0]  PCH,
  output logic        abl_co
);

  logic [7:0] abl, abh, ahl;
  logic [7:0] abl_base, abl_ofs, abh_base;
  logic [8:0] adl_sum;
  logic [7:0] adl, adh;
  logic       abh_ci;
  logic [8:0] pcl_sum;

  always_comb begin
    abl_base = abl;
    case (abl_op[3:2])
      ABL_BASE_ABL: abl_base = abl;
      ABL_BASE_PCL: abl_base = PCL;
      ABL_BASE_AHL: abl_base = ahl;
      ABL_BASE_REG: abl_base = REG;
      default:      abl_base = abl;
    endcase

    abl_ofs = 8'h00;
    case (abl_op[1:0])
      ABL_OFS_ZERO: abl_ofs = 8'h00;
      ABL_OFS_REG:  abl_ofs = REG;
      ABL_OFS_DB:   abl_ofs = DB;
      ABL_OFS_FF:   abl_ofs = 8'hFF;
      default:      abl_ofs = 8'h00;
    endcase

    abh_base = abh;
    case (abh_op[1:0])
      ABH_BASE_ABH:   abh_base = abh;
      ABH_BASE_PCH:   abh_base = PCH;
      ABH_BASE_DB:    abh_base = DB;
      ABH_BASE_STACK: abh_base = STACK_PAGE;
      default:        abh_base = abh;
    endcase
  end

  assign adl_sum = {1'b0, abl_base} + {1'b0, abl_ofs} + {8'h00, abl_ci};
  assign adl     = adl_sum[7:0];
  assign abl_co  = adl_sum[8];
  assign abh_ci  = abh_op[2] & adl_sum[8];
  // Vector fetch overrides the whole high adder, carry included.
  assign adh     = abh_ff ? VECTOR_PAGE : (abh_base + {7'h00, abh_ci});
  assign AD      = {adh, adl};

  // Increment is applied after the optional load, so ld_pc+inc_pc gives AD+1.
  assign pcl_sum = {1'b0, (ld_pc ? adl : PCL)} + {8'h00, inc_pc};

  always_ff @(posedge clk) begin
    if (RST) begin
      abl <= 8'h00;
      abh <= 8'h00;
      ahl <= 8'h00;
      PCL <= 8'h00;
      PCH <= 8'h00;
    end else begin
      abl <= adl;
      abh <= adh;
      if (ld_ahl) ahl <= DB;
      PCL <= pcl_sum[7:0];
      PCH <= (ld_pc ? adh : PCH) + {7'h00, pcl_sum[8]};
    end
  end

endmodule

// File: rtl/cpu_addr_alu.sv
// cpu_addr_alu
// 65C02 datapath core: address generator (addr_unit) plus the 8-bit ALU.
// Address and ALU outputs are combinational; only address/PC state is
// registered (inside addr_unit).
// Ports:
//   clk, RST                    clock, synchronous active-high reset
//   abl_op, abl_ci, abh_op,
//   abh_ff, ld_ahl, ld_pc,
//   inc_pc                      address microcode fields
//   DB, REG, M [7:0]            data bus, register value R, memory operand
//   alu_op[4:0], alu_ci, alu_si ALU function, carry in, shift in
//   AD, PCL, PCH, abl_co        address outputs
//   alu_out, alu_co, alu_v      ALU result, carry, signed overflow
//   bcd_cl, bcd_ch              BCD nibble carries (ADD only)
// Configuration: define CPU_BCD_EN to build the BCD carry detectors;
// otherwise bcd_cl/bcd_ch are tied 0.
import cpu_addr_alu_pkg::*;

module cpu_addr_alu (
  input  logic        clk,
  input  logic        RST,
  input  logic [3:0]  abl_op,
  input  logic        abl_ci,
  input  logic [2:0]  abh_op,
  input  logic        abh_ff,
  input  logic        ld_ahl,
  input  logic        ld_pc,
  input  logic        inc_pc,
  input  logic [7:0]  DB,
  input  logic [7:0]  REG,
  input  logic [7:0]  M,
  input  logic [4:0]  alu_op,
  input  logic        alu_ci,
  input  logic        alu_si,
  output logic [15:0] AD,
  output logic [7:0]  PCL,
  output logic [7:0]  PCH,
  output logic        abl_co,
  output logic [7:0]  alu_out,
  output logic        alu_co,
  output logic        alu_v,
  output logic        bcd_cl,
  output logic        bcd_ch
);

  addr_unit u_addr (
    .clk    (clk),
    .RST    (RST),
    .abl_op (abl_op),
    .abl_ci (abl_ci),
    .abh_op (abh_op),
    .abh_ff (abh_ff),
    .ld_ahl (ld_ahl),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .DB     (DB),
    .REG    (REG),
    .AD     (AD),
    .PCL    (PCL),
    .PCH    (PCH),
    .abl_co (abl_co)
  );

  logic [7:0] alu_b;
  logic [8:0] alu_sum;
  logic [8:0] pass_sum;
  logic       is_add;

  // One adder serves ADD and SUB; SUB adds the complement of M.
  assign is_add   = (alu_op == ALU_ADD);
  assign alu_b    = (alu_op == ALU_SUB) ? ~M : M;
  assign alu_sum  = {1'b0, REG} + {1'b0, alu_b} + {8'h00, alu_ci};
  assign pass_sum = {1'b0, REG} + {8'h00, alu_ci};

  always_comb begin
    alu_out = REG;
    alu_co  = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      ALU_OR:    alu_out = REG | M;
      ALU_AND:   alu_out = REG & M;
      ALU_EOR:   alu_out = REG ^ M;
      ALU_ADD, ALU_SUB: begin
        alu_out = alu_sum[7:0];
        alu_co  = alu_sum[8];
        alu_v   = (REG[7] == alu_b[7]) & (alu_sum[7] != REG[7]);
      end
      ALU_PASSR: begin
        alu_out = pass_sum[7:0];
        alu_co  = pass_sum[8];
      end
      ALU_PASSM: alu_out = M;
      ALU_SHL: begin
        alu_out = {M[6:0], alu_si};
        alu_co  = M[7];
      end
      ALU_SHR: begin
        alu_out = {alu_si, M[7:1]};
        alu_co  = M[0];
      end
      default:   alu_out = REG;
    endcase
  end

`ifdef CPU_BCD_EN
  logic [4:0] bcd_lo_sum;

  assign bcd_lo_sum = {1'b0, REG[3:0]} + {1'b0, M[3:0]} + {4'h0, alu_ci};
  assign bcd_cl     = is_add & (bcd_lo_sum > 5'd9);
  assign bcd_ch     = is_add & (alu_sum > 9'h099);
`else
  assign bcd_cl = 1'b0;
  assign bcd_ch = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_addr_alu.sv
module tb_cpu_addr_alu;

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        RST;
  logic [3:0]  abl_op;
  logic        abl_ci;
  logic [2:0]  abh_op;
  logic        abh_ff;
  logic        ld_ahl;
  logic        ld_pc;
  logic        inc_pc;
  logic [7:0]  DB;
  logic [7:0]  REG;
  logic [7:0]  M;
  logic [4:0]  alu_op;
  logic        alu_ci;
  logic        alu_si;
  logic [15:0] AD;
  logic [7:0]  PCL;
  logic [7:0]  PCH;
  logic        abl_co;
  logic [7:0]  alu_out;
  logic        alu_co;
  logic        alu_v;
  logic        bcd_cl;
  logic        bcd_ch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_addr_alu dut (
    .clk     (clk),
    .RST     (RST),
    .abl_op  (abl_op),
    .abl_ci  (abl_ci),
    .abh_op  (abh_op),
    .abh_ff  (abh_ff),
    .ld_ahl  (ld_ahl),
    .ld_pc   (ld_pc),
    .inc_pc  (inc_pc),
    .DB      (DB),
    .REG     (REG),
    .M       (M),
    .alu_op  (alu_op),
    .alu_ci  (alu_ci),
    .alu_si  (alu_si),
    .AD      (AD),
    .PCL     (PCL),
    .PCH     (PCH),
    .abl_co  (abl_co),
    .alu_out (alu_out),
    .alu_co  (alu_co),
    .alu_v   (alu_v),
    .bcd_cl  (bcd_cl),
    .bcd_ch  (bcd_ch)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Inputs change 1 time unit after a rising edge; outputs are sampled a
  // further unit later, well clear of the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hold();
    abl_op = 4'b0000;  // base ABL, offset 0
    abl_ci = 1'b0;
    abh_op = 3'b000;   // base ABH, no carry
    abh_ff = 1'b0;
    ld_ahl = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    DB     = 8'h00;
    REG    = 8'h00;
  endtask

  task automatic alu_vec(input string tag, input logic [4:0] op, input logic [7:0] r,
                         input logic [7:0] m, input logic ci, input logic si,
                         input logic [7:0] e_out, input logic e_co, input logic e_v);
    alu_op = op;
    REG    = r;
    M      = m;
    alu_ci = ci;
    alu_si = si;
    #1;
    check({tag, ".out"}, {8'h00, alu_out}, {8'h00, e_out});
    check({tag, ".co"},  {15'h0, alu_co},  {15'h0, e_co});
    check({tag, ".v"},   {15'h0, alu_v},   {15'h0, e_v});
  endtask

  task automatic bcd_vec(input string tag, input logic [4:0] op, input logic [7:0] r,
                         input logic [7:0] m, input logic e_cl, input logic e_ch);
    alu_op = op;
    REG    = r;
    M      = m;
    alu_ci = 1'b0;
    alu_si = 1'b0;
    #1;
`ifdef CPU_BCD_EN
    check({tag, ".cl"}, {15'h0, bcd_cl}, {15'h0, e_cl});
    check({tag, ".ch"}, {15'h0, bcd_ch}, {15'h0, e_ch});
`else
    // Feature absent: both carries must stay 0 regardless of operands.
    check({tag, ".cl"}, {15'h0, bcd_cl}, 16'h0000);
    check({tag, ".ch"}, {15'h0, bcd_ch}, 16'h0000);
    if (e_cl === 1'bx || e_ch === 1'bx) $display("note: unexpected X expectation");
`endif
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    RST    = 1'b1;
    M      = 8'h00;
    alu_op = 5'h00;
    alu_ci = 1'b0;
    alu_si = 1'b0;
    set_hold();
    #1;
    step();
    RST = 1'b0;
    #1;
    check("rst.ad",  AD, 16'h0000);
    check("rst.pcl", {8'h00, PCL}, 16'h0000);
    check("rst.pch", {8'h00, PCH}, 16'h0000);
    step();
    check("hold.ad", AD, 16'h0000);

    // Vector fetch: base REG=0xFC, ADH forced to 0xFF.
    abl_op = {2'b11, 2'b00};
    REG    = 8'hFC;
    abh_ff = 1'b1;
    #1;
    check("vec.ad0", AD, 16'hFFFC);
    step();
    set_hold();
    abl_ci = 1'b1;
    #1;
    check("vec.ad1", AD, 16'hFFFD);

    // Page cross: load ABL=0xF0, ABH=0x12, then add REG=0x20 with carry into ADH.
    set_hold();
    abl_op = {2'b11, 2'b00};
    REG    = 8'hF0;
    abh_op = 3'b010;
    DB     = 8'h12;
    step();
    set_hold();
    abl_op = {2'b00, 2'b01};
    REG    = 8'h20;
    abh_op = 3'b100;
    #1;
    check("page.ad", AD, 16'h1310);
    check("page.co", {15'h0, abl_co}, 16'h0001);
    // Same add without ADH carry source keeps the page.
    abh_op = 3'b000;
    #1;
    check("page.noci", AD, 16'h1210);

    // PC load + increment from AD=0x12FF.
    set_hold();
    abl_op = {2'b11, 2'b00};
    REG    = 8'hFF;
    abh_op = 3'b010;
    DB     = 8'h12;
    ld_pc  = 1'b1;
    inc_pc = 1'b1;
    step();
    check("pc.ldinc", {PCH, PCL}, 16'h1300);

    // PC load 0xFFFF, then increment wraps to 0x0000.
    set_hold();
    abl_op = {2'b11, 2'b00};
    REG    = 8'hFF;
    abh_ff = 1'b1;
    ld_pc  = 1'b1;
    step();
    check("pc.ld", {PCH, PCL}, 16'hFFFF);
    set_hold();
    inc_pc = 1'b1;
    step();
    check("pc.wrap", {PCH, PCL}, 16'h0000);
    step();
    check("pc.inc", {PCH, PCL}, 16'h0001);

    // PC-based address: PCL + 0xFF carries into PCH base.
    set_hold();
    abl_op = {2'b01, 2'b11};
    abh_op = 3'b101;
    #1;
    check("pcrel.ad", AD, 16'h0100);
    check("pcrel.co", {15'h0, abl_co}, 16'h0001);

    // AHL: same-cycle load is not seen; next cycle it is. Stack page base.
    set_hold();
    ld_ahl = 1'b1;
    DB     = 8'h5A;
    abl_op = {2'b10, 2'b00};
    abh_op = 3'b011;
    #1;
    check("ahl.old", AD, 16'h0100);
    step();
    set_hold();
    abl_op = {2'b10, 2'b00};
    abh_op = 3'b011;
    #1;
    check("ahl.new", AD, 16'h015A);
    // DB offset on AHL base.
    abl_op = {2'b10, 2'b10};
    DB     = 8'h10;
    #1;
    check("ahl.db", AD, 16'h016A);

    // ALU vectors
    alu_vec("add",   5'h03, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    alu_vec("addc",  5'h03, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    alu_vec("sub",   5'h04, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    alu_vec("subv",  5'h04, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    alu_vec("subb",  5'h04, 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    alu_vec("or",    5'h00, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    alu_vec("and",   5'h01, 8'hF3, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
    alu_vec("eor",   5'h02, 8'hF3, 8'h3C, 1'b0, 1'b0, 8'hCF, 1'b0, 1'b0);
    alu_vec("passr", 5'h05, 8'hFF, 8'h12, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    alu_vec("passm", 5'h06, 8'h11, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    alu_vec("shl",   5'h07, 8'h00, 8'h81, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0);
    alu_vec("shr",   5'h08, 8'h00, 8'h81, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b0);
    alu_vec("undef", 5'h1F, 8'h3C, 8'hFF, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);

    // BCD carries
    bcd_vec("bcd.lo",  5'h03, 8'h09, 8'h01, 1'b1, 1'b0);
    bcd_vec("bcd.hi",  5'h03, 8'h99, 8'h01, 1'b1, 1'b1);
    bcd_vec("bcd.no",  5'h03, 8'h45, 8'h44, 1'b0, 1'b0);
    bcd_vec("bcd.sub", 5'h04, 8'h99, 8'h01, 1'b0, 1'b0);

    // ---------------------------------------------------------------- report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
